// File: rtl/rvj1_ifu_if.sv
// -----------------------------------------------------------------------------
// rvj1_ifu_if -- instruction memory bus between the fetch unit and imem.
//
// Signals (named from the fetch unit's point of view):
//   imem_req_o     fetch unit -> imem  request valid
//   imem_addr_o    fetch unit -> imem  word address, bits [1:0] always zero
//   imem_gnt_i     imem -> fetch unit  request accepted this cycle
//   imem_rvalid_i  imem -> fetch unit  read data valid, in request order
//   imem_rdata_i   imem -> fetch unit  read data
//
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface rvj1_ifu_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/rvj1_ifu.sv
// -----------------------------------------------------------------------------
// rvj1_ifu -- instruction fetch unit.
//
// Issues sequential word fetches to the instruction memory, buffers the
// in-order responses in a small FIFO of {addr, data} pairs and presents the
// head to decode. A jump flushes the buffer, redirects fetch and drops the
// responses of requests that were already in flight.
//
// Ports:
//   clk_i          core clock, rising edge
//   rstn_i         synchronous active-low reset
//   stall_i        decode stall; holds the presented instruction
//   jmp_i          one-cycle redirect strobe
//   jmp_addr_i     redirect target (bits [1:0] ignored)
//   imem           instruction memory bus (master side)
//   instr_o        instruction presented to decode
//   instr_addr_o   address of instr_o
//   instr_valid_o  instr_o / instr_addr_o valid
// -----------------------------------------------------------------------------
module rvj1_ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h8000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            stall_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_addr_i,
  rvj1_ifu_if.master      imem,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_addr_o,
  output logic            instr_valid_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding_cnt;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   fifo_cnt;

  // In-flight request addresses, oldest at pend_rd. Its occupancy always
  // equals outstanding_cnt, so it needs no counter of its own.
  logic [XLEN-1:0] pend_addr [FIFO_DEPTH];
  logic [PW-1:0]   pend_rd, pend_wr;

  // Instruction buffer.
  logic [XLEN-1:0] fifo_addr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   fifo_rd, fifo_wr;

  logic          fifo_empty;
  logic          pop;
  logic          grant;
  logic          resp;
  logic          push;
  logic [OW-1:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    fifo_empty    = (fifo_cnt == '0);
    instr_valid_o = rstn_i && !fifo_empty && !jmp_i;
    pop           = instr_valid_o && !stall_i;
    instr_o       = (rstn_i && !fifo_empty) ? fifo_data[fifo_rd] : '0;
    instr_addr_o  = (rstn_i && !fifo_empty) ? fifo_addr[fifo_rd] : '0;

    // Every in-flight fetch owns a buffer slot, which makes overflow
    // impossible and keeps the request stable until granted.
    occupancy        = {1'b0, outstanding_cnt} + {1'b0, fifo_cnt} - OW'(pop);
    imem.imem_req_o  = rstn_i && !jmp_i && (occupancy < OW'(FIFO_DEPTH));
    imem.imem_addr_o = {fetch_pc[XLEN-1:2], 2'b00};

    grant = imem.imem_req_o && imem.imem_gnt_i;
    // A response with nothing outstanding is a leftover from before reset.
    resp  = imem.imem_rvalid_i && (outstanding_cnt != '0);
    push  = rstn_i && resp && !jmp_i && (discard_cnt == '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_pc        <= BOOT_ADDR;
      outstanding_cnt <= '0;
      discard_cnt     <= '0;
      fifo_cnt        <= '0;
      pend_rd         <= '0;
      pend_wr         <= '0;
      fifo_rd         <= '0;
      fifo_wr         <= '0;
    end else begin
      if (grant) pend_wr <= ptr_inc(pend_wr);
      if (resp)  pend_rd <= ptr_inc(pend_rd);

      case ({grant, resp})
        2'b10:   outstanding_cnt <= outstanding_cnt + CW'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CW'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase

      if (jmp_i) begin
        // No grant is possible this cycle; a response arriving now is stale
        // and is dropped along with everything still in flight.
        fetch_pc    <= {jmp_addr_i[XLEN-1:2], 2'b00};
        discard_cnt <= outstanding_cnt - CW'(resp);
        fifo_cnt    <= '0;
        fifo_rd     <= '0;
        fifo_wr     <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
        if (push) fifo_wr <= ptr_inc(fifo_wr);
        if (pop)  fifo_rd <= ptr_inc(fifo_rd);
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // NOTE: storage arrays carry no reset; the counters and pointers define
  // which entries are meaningful, and empty-buffer outputs are forced to 0.
  always_ff @(posedge clk_i) begin
    if (grant) pend_addr[pend_wr] <= imem.imem_addr_o;
    if (push) begin
      fifo_addr[fifo_wr] <= pend_addr[pend_rd];
      fifo_data[fifo_wr] <= imem.imem_rdata_i;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))));

  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(grant && !resp && (outstanding_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_rvj1_ifu.sv
// -----------------------------------------------------------------------------
// tb_rvj1_ifu -- self-checking bench for rvj1_ifu.
//
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The memory model answers granted requests in order after a configurable
// latency with data = address ^ key. A stream model tracks which address
// decode must see next (sequential from the last reset/jump target) and
// checks every presented instruction against it.
// -----------------------------------------------------------------------------
module tb_rvj1_ifu;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn_i, stall_i, jmp_i;
  logic [31:0] jmp_addr_i;
  logic [31:0] instr_o, instr_addr_o;
  logic        instr_valid_o;

  rvj1_ifu_if #(.XLEN(32)) bus ();

  rvj1_ifu #(.XLEN(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .stall_i      (stall_i),
    .jmp_i        (jmp_i),
    .jmp_addr_i   (jmp_addr_i),
    .imem         (bus),
    .instr_o      (instr_o),
    .instr_addr_o (instr_addr_o),
    .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model state
  logic [31:0] memq [$];
  int unsigned dueq [$];
  int unsigned cyc      = 0;
  int unsigned mem_lat  = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] key      = 32'h0;

  // Samples of the current cycle
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_iaddr;

  // Stream model state
  logic [31:0] exp_next = BOOT;
  bit          prev_hold = 1'b0;
  bit          prev_req_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          pops_total = 0;

  task automatic cycle(input logic rst_n, input logic stall, input logic jmp,
                       input logic [31:0] jaddr, input logic gnt, input logic stray);
    logic        rv;
    logic [31:0] rd;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (stray) rv = 1'b1;
    else if (memq.size() > 0 && dueq[0] <= cyc) begin
      rv = 1'b1;
      rd = memq[0] ^ key;
    end
    rstn_i            = rst_n;
    stall_i           = stall;
    jmp_i             = jmp;
    jmp_addr_i        = jaddr;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rd;
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = instr_valid_o;
    s_instr = instr_o;
    s_iaddr = instr_addr_o;

    if (!rst_n) begin
      check("rst_req", s_req, 0);
      check("rst_valid", s_valid, 0);
      check("rst_instr", s_instr, 0);
      check("rst_instr_addr", s_iaddr, 0);
      exp_next         = BOOT;
      prev_hold        = 1'b0;
      prev_req_pending = 1'b0;
    end else begin
      if (jmp) begin
        check("jmp_valid_low", s_valid, 0);
        check("jmp_req_low", s_req, 0);
      end else begin
        if (prev_hold) check("stall_keeps_valid", s_valid, 1);
        if (prev_req_pending) begin
          check("req_held_until_gnt", s_req, 1);
          check("addr_held_until_gnt", s_addr, prev_addr);
        end
        if (s_valid) begin
          check("stream_addr", s_iaddr, exp_next);
          check("stream_data", s_instr, exp_next ^ key);
          if (!stall) begin
            exp_next += 32'd4;
            pops_total++;
          end
        end
      end
      if (s_req) check("addr_aligned", {30'h0, s_addr[1:0]}, 0);
      prev_hold        = s_valid && stall && !jmp;
      prev_req_pending = s_req && !gnt;
      prev_addr        = s_addr;
      if (jmp) exp_next = {jaddr[31:2], 2'b00};
    end

    if (rv && !stray) begin
      void'(memq.pop_front());
      void'(dueq.pop_front());
    end
    if (s_req && gnt) begin
      memq.push_back(s_addr);
      dueq.push_back(cyc + (rand_lat ? $urandom_range(1, 3) : mem_lat));
    end
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic reset_one();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    memq.delete();
    dueq.delete();
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (!s_valid && n < max_cycles);
    check(name, s_valid, 1);
  endtask

  typedef struct {
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_iaddr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          n;
    int          pops_start;

    // Zero-wait stream from reset, then grant withheld for three cycles.
    vecs[0]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
    vecs[3]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
    vecs[4]  = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
    vecs[5]  = '{1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
    vecs[6]  = '{1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0010};
    vecs[7]  = '{1'b0, 1'b1, 32'h8000_0014, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h8000_0014, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h8000_0018, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0014};

    rstn_i = 1'b0; stall_i = 1'b0; jmp_i = 1'b0; jmp_addr_i = 32'h0;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;

    repeat (3) reset_one();

    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, vecs[i].gnt, 1'b0);
      check($sformatf("tbl%0d_req", i), s_req, vecs[i].exp_req);
      check($sformatf("tbl%0d_addr", i), s_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl%0d_instr_addr", i), s_iaddr, vecs[i].exp_iaddr);
        check($sformatf("tbl%0d_instr", i), s_instr, vecs[i].exp_iaddr);
      end
    end

    // Five-cycle stall mid-stream.
    idle();
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 0) held = s_iaddr;
      else check("stall_instr_addr_held", s_iaddr, held);
      check("stall_valid", s_valid, 1);
    end
    check("stall_no_req", s_req, 0);
    check("stall_nothing_in_flight", memq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_stall_valid", s_valid, 1);
      check("post_stall_addr", s_iaddr, held + 32'(4 * i));
    end

    // Jump with two fetches in flight (latency 2).
    reset_one();
    mem_lat = 2;
    n = 0;
    do begin idle(); n++; end while (memq.size() < 2 && n < 10);
    check("jmp_setup_in_flight", memq.size(), 2);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
    wait_valid("jmp_target_seen", 12);
    check("jmp_target_addr", s_iaddr, 32'h0000_0100);
    check("jmp_target_data", s_instr, 32'h0000_0100);
    wait_valid("jmp_next_seen", 12);
    check("jmp_next_addr", s_iaddr, 32'h0000_0104);

    // Jump to the top word: fetch address wraps to 0.
    mem_lat = 1;
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    wait_valid("wrap_first_seen", 12);
    check("wrap_first_addr", s_iaddr, 32'hFFFF_FFFC);
    wait_valid("wrap_second_seen", 12);
    check("wrap_second_addr", s_iaddr, 32'h0000_0000);
    check("wrap_second_data", s_instr, 32'h0000_0000);

    // One-cycle reset with two in flight, then a stray response.
    reset_one();
    mem_lat = 3;
    n = 0;
    do begin idle(); n++; end while (memq.size() < 2 && n < 10);
    check("rst_setup_in_flight", memq.size(), 2);
    reset_one();
    mem_lat = 1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("stray_c0_valid", s_valid, 0);
    idle();
    check("stray_c1_valid", s_valid, 0);
    idle();
    check("stray_c2_valid", s_valid, 1);
    check("stray_c2_addr", s_iaddr, BOOT);
    check("stray_c2_data", s_instr, BOOT);

    // Randomised traffic against the stream model.
    reset_one();
    key        = 32'h3C5A_96E1;
    rand_lat   = 1'b1;
    pops_start = pops_total;
    for (int i = 0; i < 3000; i++) begin
      logic        st, jp, gn;
      logic [31:0] ja;
      st = ($urandom_range(0, 9) < 3);
      jp = ($urandom_range(0, 49) == 0);
      gn = ($urandom_range(0, 3) != 0);
      ja = $urandom;
      if ($urandom_range(0, 7) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hF);
      cycle(1'b1, st, jp, ja, gn, 1'b0);
      check("in_flight_bound", 32'(memq.size() <= DEPTH), 1);
    end
    check("random_progress", 32'(pops_total - pops_start > 500), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
